i2c_reg_sequencer: RTL and testbench

Transaction-level controller that sequences the byte-level i2c engine (START/STOP/READ_BYTE/WRITE_BYTE primitives) to perform complete register writes and register reads on one 7-bit slave.
Sits between the pwm_ctrl register/control logic and the i2c engine. Example slave: the motor angle sensor.
Owns the engine's instruction, enable, byteToSend and send_nack inputs exclusively.

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_step_rom.sv | 47 ++++
 rtl/i2c_reg_sequencer.sv | 178 +++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c register sequencer: engine op codes, top FSM
// states and the step-program constants.
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_READ  = 2'd2,
    OP_WRITE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } state_e;

  typedef enum logic [2:0] {
    BS_NONE,
    BS_ADDR_W,
    BS_ADDR_R,
    BS_REG,
    BS_DATA
  } byte_sel_e;

  localparam logic [3:0] STEP_W_STOP   = 4'd4;
  localparam logic [3:0] STEP_RD_FIRST = 4'd5;

  // Index of the STOP step for the selected program.
  function automatic logic [3:0] stop_step(input logic rw, input int unsigned num_rd);
    return rw ? 4'(32'(STEP_RD_FIRST) + num_rd) : STEP_W_STOP;
  endfunction

endpackage

// File: rtl/i2c_step_rom.sv
// Fixed primitive program: maps (rw, step) to engine op, byte source and a
// last-step flag.
module i2c_step_rom
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_RD_BYTES = 2
) (
  input  logic       rw,
  input  logic [3:0] step,
  output logic [1:0] op,
  output logic [2:0] byte_sel,
  output logic       is_last
);

  localparam logic [3:0] RD_STOP = stop_step(1'b1, NUM_RD_BYTES);

  op_e       op_n;
  byte_sel_e sel_n;

  always_comb begin
    op_n  = OP_STOP;
    sel_n = BS_NONE;
    if (!rw) begin
      case (step)
        4'd0: op_n = OP_START;
        4'd1: begin op_n = OP_WRITE; sel_n = BS_ADDR_W; end
        4'd2: begin op_n = OP_WRITE; sel_n = BS_REG;    end
        4'd3: begin op_n = OP_WRITE; sel_n = BS_DATA;   end
        default: ;
      endcase
    end else begin
      case (step)
        4'd0: op_n = OP_START;
        4'd1: begin op_n = OP_WRITE; sel_n = BS_ADDR_W; end
        4'd2: begin op_n = OP_WRITE; sel_n = BS_REG;    end
        4'd3: op_n = OP_START;
        4'd4: begin op_n = OP_WRITE; sel_n = BS_ADDR_R; end
        default: if (step < RD_STOP) op_n = OP_READ;
      endcase
    end
  end

  assign op       = op_n;
  assign byte_sel = sel_n;
  assign is_last  = (op_n == OP_STOP);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Sequences byte-level i2c engine primitives into complete register writes and
// reads on one slave. Optional per-primitive watchdog: define I2C_TIMEOUT_EN.
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h36,
  parameter int unsigned NUM_RD_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2047
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rw,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] rd_data,
  output logic [1:0]  i2c_instruction,
  output logic        i2c_enable,
  output logic [7:0]  i2c_byte_to_send,
  output logic        i2c_send_nack,
  input  logic [7:0]  i2c_byte_received,
  input  logic        i2c_complete
);

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic        rw_q, rw_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        first_q, first_d;

  logic [1:0]  op;
  logic [2:0]  byte_sel;
  logic        is_last;
  logic [7:0]  tx_byte;

`ifdef I2C_TIMEOUT_EN
  localparam logic [10:0] TO_LIMIT = 11'(TIMEOUT_CYCLES);
  logic [10:0] cnt_q, cnt_d;
  logic        error_q, error_d;
  assign error = error_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign error = 1'b0;
`endif

  i2c_step_rom #(.NUM_RD_BYTES(NUM_RD_BYTES)) u_rom (
    .rw      (rw_q),
    .step    (step_q),
    .op      (op),
    .byte_sel(byte_sel),
    .is_last (is_last)
  );

  always_comb begin
    tx_byte = 8'h00;
    case (byte_sel)
      BS_ADDR_W: tx_byte = {DEV_ADDR, 1'b0};
      BS_ADDR_R: tx_byte = {DEV_ADDR, 1'b1};
      BS_REG:    tx_byte = reg_addr_q;
      BS_DATA:   tx_byte = wr_data_q;
      default:   tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    rw_d       = rw_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    first_d    = first_q;
`ifdef I2C_TIMEOUT_EN
    cnt_d      = cnt_q;
    error_d    = error_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rw_d       = rw;
          reg_addr_d = reg_addr;
          wr_data_d  = wr_data;
          rd_data_d  = '0;
          step_d     = '0;
`ifdef I2C_TIMEOUT_EN
          error_d    = 1'b0;
`endif
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        first_d = 1'b1;
`ifdef I2C_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        first_d = 1'b0;
`ifdef I2C_TIMEOUT_EN
        cnt_d   = cnt_q + 11'd1;
`endif
        // The engine still shows the previous complete while accepting the op.
        if (i2c_complete && !first_q) begin
          if (op == OP_READ) begin
            rd_data_d = (NUM_RD_BYTES == 1) ? {i2c_byte_received, 8'h00}
                                            : {rd_data_q[7:0], i2c_byte_received};
          end
          state_d = ST_NEXT;
        end
`ifdef I2C_TIMEOUT_EN
        else if (cnt_q == TO_LIMIT) begin
          error_d = 1'b1;
          if (is_last) begin
            state_d = ST_FINISH;
          end else begin
            step_d  = stop_step(rw_q, NUM_RD_BYTES);
            state_d = ST_ISSUE;
          end
        end
`endif
      end
      ST_NEXT: begin
        if (is_last) begin
          state_d = ST_FINISH;
        end else begin
          step_d  = step_q + 4'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      rw_q       <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      first_q    <= 1'b0;
`ifdef I2C_TIMEOUT_EN
      cnt_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      rw_q       <= rw_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      first_q    <= first_d;
`ifdef I2C_TIMEOUT_EN
      cnt_q      <= cnt_d;
      error_q    <= error_d;
`endif
    end
  end

  assign busy             = state_q inside {ST_ISSUE, ST_WAIT, ST_NEXT};
  assign done             = (state_q == ST_FINISH);
  assign rd_data          = rd_data_q;
  assign i2c_enable       = (state_q == ST_ISSUE);
  assign i2c_instruction  = op;
  assign i2c_byte_to_send = tx_byte;
  assign i2c_send_nack    = 1'b0;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: two instances (2-byte and 1-byte reads) driven
// against a behavioural i2c engine model; I2C_TIMEOUT_EN adds the watchdog test.
module tb_i2c_reg_sequencer;

  localparam logic [6:0] DEV = 7'h36;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] start = '0;
  logic rw = 1'b0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wr_data = '0;

  logic [1:0] busy, done, error, en, nack, cmp;
  logic [1:0][15:0] rd_data;
  logic [1:0][1:0] instr;
  logic [1:0][7:0] tx, rx;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.DEV_ADDR(DEV), .NUM_RD_BYTES(2), .TIMEOUT_CYCLES(2047)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .rw(rw), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy[0]), .done(done[0]), .error(error[0]),
    .rd_data(rd_data[0]), .i2c_instruction(instr[0]), .i2c_enable(en[0]),
    .i2c_byte_to_send(tx[0]), .i2c_send_nack(nack[0]),
    .i2c_byte_received(rx[0]), .i2c_complete(cmp[0]));

  i2c_reg_sequencer #(.DEV_ADDR(DEV), .NUM_RD_BYTES(1), .TIMEOUT_CYCLES(2047)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .rw(rw), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy[1]), .done(done[1]), .error(error[1]),
    .rd_data(rd_data[1]), .i2c_instruction(instr[1]), .i2c_enable(en[1]),
    .i2c_byte_to_send(tx[1]), .i2c_send_nack(nack[1]),
    .i2c_byte_received(rx[1]), .i2c_complete(cmp[1]));

  // Behavioural engine: one op per enable, complete pulse lat cycles later.
  int unsigned lat[2] = '{20, 20};
  int          hold_idx[2] = '{-1, -1};
  int          cnt[2];
  bit          eng_busy[2], prev_en[2], cur_hold[2];
  logic [1:0]  cur_op[2];
  int          n_en[2] = '{0, 0};
  int          viol[2] = '{0, 0};
  logic [9:0]  log_q[2][$];
  logic [7:0]  rdq[2][$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        eng_busy[c] <= 1'b0;
        prev_en[c]  <= 1'b0;
        cur_hold[c] <= 1'b0;
        cnt[c]      <= 0;
        cmp[c]      <= 1'b0;
        rx[c]       <= 8'h00;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        prev_en[c] <= en[c];
        cmp[c]     <= 1'b0;
        if (en[c]) begin
          if (prev_en[c]) viol[c] <= viol[c] + 1;
          log_q[c].push_back({instr[c], tx[c]});
          cur_hold[c] <= (n_en[c] == hold_idx[c]);
          n_en[c]     <= n_en[c] + 1;
          cur_op[c]   <= instr[c];
          eng_busy[c] <= 1'b1;
          cnt[c]      <= int'(lat[c]);
        end else if (eng_busy[c] && !cur_hold[c]) begin
          if (cnt[c] <= 1) begin
            eng_busy[c] <= 1'b0;
            cmp[c]      <= 1'b1;
            if (cur_op[c] == 2'd2) begin
              if (rdq[c].size() != 0) rx[c] <= rdq[c].pop_front();
              else rx[c] <= 8'hEE;
            end
          end else begin
            cnt[c] <= cnt[c] - 1;
          end
        end
      end
    end
  end

  // Reference op list from the transaction rules: {op[1:0], byte[7:0]}.
  logic [9:0] exp_q[$];

  function automatic void build_exp(input logic rw_i, input logic [7:0] ra,
                                    input logic [7:0] wd, input int nrd);
    exp_q.delete();
    exp_q.push_back({2'd0, 8'h00});
    exp_q.push_back({2'd3, DEV, 1'b0});
    exp_q.push_back({2'd3, ra});
    if (!rw_i) begin
      exp_q.push_back({2'd3, wd});
    end else begin
      exp_q.push_back({2'd0, 8'h00});
      exp_q.push_back({2'd3, DEV, 1'b1});
      for (int i = 0; i < nrd; i++) exp_q.push_back({2'd2, 8'h00});
    end
    exp_q.push_back({2'd1, 8'h00});
  endfunction

  // -1 when the logged ops equal exp_q; byte compared only for WRITE ops.
  function automatic int ops_diff(input int c);
    if (log_q[c].size() != exp_q.size()) return -2;
    foreach (exp_q[i]) begin
      if (log_q[c][i][9:8] !== exp_q[i][9:8]) return i;
      if (exp_q[i][9:8] == 2'd3 && log_q[c][i][7:0] !== exp_q[i][7:0]) return i;
    end
    return -1;
  endfunction

  task automatic do_txn(input int c, input logic rw_i, input logic [7:0] ra,
                        input logic [7:0] wd, output logic [15:0] rd, output logic err,
                        output int dn, output bit acc, output bit to);
    rd = '0; err = 1'b0; dn = 0; to = 1'b1;
    log_q[c].delete();
    rw = rw_i; reg_addr = ra; wr_data = wd; start[c] = 1'b1;
    @(negedge clk);
    start[c] = 1'b0;
    acc = busy[c];
    rw = ~rw_i; reg_addr = ~ra; wr_data = 8'($urandom);
    for (int k = 0; k < 6000; k++) begin
      if (done[c]) begin
        dn++; rd = rd_data[c]; err = error[c]; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      if (done[c]) dn++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      v = {busy[c], done[c], error[c], rd_data[c], en[c], instr[c], tx[c], nack[c]};
      total_cnt++;
      if (v !== '0) $display("FAIL reset_hold ch%0d: outputs %h want 0", c, v);
      else pass_cnt++;
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      v = {busy[c], done[c], error[c], rd_data[c], en[c], instr[c], tx[c], nack[c]};
      total_cnt++;
      if (v !== '0) $display("FAIL reset_idle ch%0d: outputs %h want 0", c, v);
      else pass_cnt++;
    end
  endtask

  task automatic test_write;
    logic [15:0] rd; logic err; int dn, d; bit acc, to;
    lat[0] = 20;
    do_txn(0, 1'b0, 8'h0C, 8'hA5, rd, err, dn, acc, to);
    build_exp(1'b0, 8'h0C, 8'hA5, 2);
    d = ops_diff(0);
    total_cnt++;
    if (d != -1) $display("FAIL write_ops: got %0d ops want %0d (diff %0d)", log_q[0].size(), exp_q.size(), d);
    else pass_cnt++;
    total_cnt++;
    if (acc !== 1'b1) $display("FAIL write_busy: got %b want 1", acc); else pass_cnt++;
    total_cnt++;
    if (dn != 1 || to) $display("FAIL write_done: got %0d pulses (timeout %b) want 1", dn, to);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL write_error: got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_read2;
    logic [15:0] rd; logic err; int dn, d; bit acc, to;
    lat[0] = 20;
    rdq[0].delete(); rdq[0].push_back(8'h0F); rdq[0].push_back(8'h3C);
    do_txn(0, 1'b1, 8'h0E, 8'h00, rd, err, dn, acc, to);
    build_exp(1'b1, 8'h0E, 8'h00, 2);
    d = ops_diff(0);
    total_cnt++;
    if (d != -1) $display("FAIL read2_ops: got %0d ops want %0d (diff %0d)", log_q[0].size(), exp_q.size(), d);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 16'h0F3C) $display("FAIL read2_data: got %h want 0f3c", rd); else pass_cnt++;
    total_cnt++;
    if (dn != 1 || err !== 1'b0) $display("FAIL read2_done: got %0d pulses err %b want 1 err 0", dn, err);
    else pass_cnt++;
  endtask

  task automatic test_read1;
    logic [15:0] rd; logic err; int dn, d, base; bit acc, to;
    lat[1] = 20;
    base = n_en[1];
    rdq[1].delete(); rdq[1].push_back(8'h7E);
    do_txn(1, 1'b1, 8'h0E, 8'h00, rd, err, dn, acc, to);
    build_exp(1'b1, 8'h0E, 8'h00, 1);
    d = ops_diff(1);
    total_cnt++;
    if (d != -1) $display("FAIL read1_ops: got %0d ops want %0d (diff %0d)", log_q[1].size(), exp_q.size(), d);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 16'h7E00) $display("FAIL read1_data: got %h want 7e00", rd); else pass_cnt++;
    total_cnt++;
    if (n_en[1] - base != 7) $display("FAIL read1_enables: got %0d want 7", n_en[1] - base);
    else pass_cnt++;
  endtask

  task automatic test_busy_start;
    logic [15:0] rd; logic err; int dn, d; bit acc, to, got;
    lat[0] = 20;
    log_q[0].delete();
    rw = 1'b0; reg_addr = 8'h21; wr_data = 8'h5A; start[0] = 1'b1;
    dn = 0; got = 1'b0;
    for (int k = 1; k < 6000 && !got; k++) begin
      @(negedge clk);
      start[0] = (k == 5 || k == 40);
      rw = 1'b1; reg_addr = 8'($urandom); wr_data = 8'($urandom);
      if (done[0]) begin
        got = 1'b1; dn++;
        start[0] = 1'b1;
      end
    end
    @(negedge clk);
    start[0] = 1'b0;
    build_exp(1'b0, 8'h21, 8'h5A, 2);
    d = ops_diff(0);
    total_cnt++;
    if (d != -1) $display("FAIL busy_start_ops: got %0d ops want %0d (diff %0d)", log_q[0].size(), exp_q.size(), d);
    else pass_cnt++;
    total_cnt++;
    if (dn != 1) $display("FAIL busy_start_done: got %0d pulses want 1", dn); else pass_cnt++;
    total_cnt++;
    if (busy[0] !== 1'b0) $display("FAIL start_with_done: busy %b want 0", busy[0]); else pass_cnt++;
    // Start in the cycle right after done must be taken.
    rdq[0].delete(); rdq[0].push_back(8'hC3); rdq[0].push_back(8'h18);
    do_txn(0, 1'b1, 8'h33, 8'h00, rd, err, dn, acc, to);
    build_exp(1'b1, 8'h33, 8'h00, 2);
    d = ops_diff(0);
    total_cnt++;
    if (!acc || d != -1 || dn != 1 || rd !== 16'hC318)
      $display("FAIL after_done_start: acc %b diff %0d done %0d rd %h want 1 -1 1 c318", acc, d, dn, rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd; logic err; int dn, d, base; bit acc, to;
    logic [31:0] v;
    lat[0] = 20;
    log_q[0].delete();
    base = n_en[0];
    rw = 1'b0; reg_addr = 8'h44; wr_data = 8'h11; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 500 && n_en[0] - base < 3; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (busy[0] !== 1'b0 || en[0] !== 1'b0)
      $display("FAIL reset_mid_now: busy %b enable %b want 0 0", busy[0], en[0]);
    else pass_cnt++;
    v = {busy[0], done[0], error[0], rd_data[0], en[0], instr[0], tx[0], nack[0]};
    total_cnt++;
    if (v !== '0) $display("FAIL reset_mid_outputs: got %h want 0", v); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (log_q[0].size() != 3) $display("FAIL reset_mid_nostop: got %0d ops want 3", log_q[0].size());
    else pass_cnt++;
    do_txn(0, 1'b0, 8'h45, 8'h96, rd, err, dn, acc, to);
    build_exp(1'b0, 8'h45, 8'h96, 2);
    d = ops_diff(0);
    total_cnt++;
    if (d != -1 || dn != 1) $display("FAIL reset_mid_recover: diff %0d done %0d want -1 1", d, dn);
    else pass_cnt++;
  endtask

`ifdef I2C_TIMEOUT_EN
  task automatic test_timeout;
    logic [15:0] rd; logic err; int dn, d; bit acc, to;
    lat[0] = 20;
    hold_idx[0] = n_en[0] + 2;
    do_txn(0, 1'b0, 8'h0C, 8'hA5, rd, err, dn, acc, to);
    hold_idx[0] = -1;
    build_exp(1'b0, 8'h0C, 8'hA5, 2);
    exp_q.delete(3);
    d = ops_diff(0);
    total_cnt++;
    if (d != -1) $display("FAIL timeout_ops: got %0d ops want %0d (diff %0d)", log_q[0].size(), exp_q.size(), d);
    else pass_cnt++;
    total_cnt++;
    if (dn != 1 || to || err !== 1'b1)
      $display("FAIL timeout_done: done %0d timeout %b err %b want 1 0 1", dn, to, err);
    else pass_cnt++;
  endtask
`endif

  task automatic test_back_to_back;
    logic [15:0] rd, exp_rd; logic err; int dn, d, c, nrd; bit acc, to;
    logic rw_i; logic [7:0] ra, wd, b0, b1;
    for (int k = 0; k < 12; k++) begin
      c = int'($urandom_range(0, 1));
      nrd = (c == 0) ? 2 : 1;
      rw_i = 1'($urandom); ra = 8'($urandom); wd = 8'($urandom);
      b0 = 8'($urandom); b1 = 8'($urandom);
      lat[c] = $urandom_range(1, 25);
      rdq[c].delete(); rdq[c].push_back(b0);
      if (nrd == 2) rdq[c].push_back(b1);
      do_txn(c, rw_i, ra, wd, rd, err, dn, acc, to);
      build_exp(rw_i, ra, wd, nrd);
      exp_rd = !rw_i ? 16'h0000 : (nrd == 2 ? {b0, b1} : {b0, 8'h00});
      d = ops_diff(c);
      total_cnt++;
      if (d != -1) $display("FAIL rand%0d_ops ch%0d: got %0d ops want %0d (diff %0d)", k, c, log_q[c].size(), exp_q.size(), d);
      else pass_cnt++;
      total_cnt++;
      if (rd !== exp_rd) $display("FAIL rand%0d_rd ch%0d: got %h want %h", k, c, rd, exp_rd);
      else pass_cnt++;
      total_cnt++;
      if (dn != 1 || err !== 1'b0) $display("FAIL rand%0d_done ch%0d: done %0d err %b want 1 0", k, c, dn, err);
      else pass_cnt++;
    end
  endtask

  task automatic test_protocol;
    total_cnt++;
    if (viol[0] != 0 || viol[1] != 0)
      $display("FAIL enable_spacing: back-to-back enables %0d/%0d want 0/0", viol[0], viol[1]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read2;
    test_read1;
    test_busy_start;
    test_reset_mid;
`ifdef I2C_TIMEOUT_EN
    test_timeout;
`endif
    test_back_to_back;
    test_protocol;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
